// File: rtl/jtvigil_pkg.sv
// Shared constants and types for the Vigilante sound-side latch and PCM link.
// Holds the IM0 vector encoding and the PCM fetch state enumeration.
package jtvigil_pkg;

  localparam logic [7:0] VEC_NONE      = 8'hFF;
  localparam int         VEC_LATCH_BIT = 5;
  localparam int         VEC_YM_BIT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READY
  } pcm_st_t;

endpackage

// File: rtl/jtvigil_pcm_ptr.sv
// PCM sample pointer: start-address load, ROM fetch with CPU wait, DAC register.
// Ports: clk, rst, snd_dout, smp_lo_wr, smp_hi_wr, smp_rd, dac_wr (sound CPU side);
//   smp_dout, smp_wait_n (CPU read path); pcm_addr, pcm_cs, pcm_data, pcm_ok (ROM); dac.
module jtvigil_pcm_ptr
  import jtvigil_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    snd_dout,
  input  logic          smp_lo_wr,
  input  logic          smp_hi_wr,
  input  logic          smp_rd,
  input  logic          dac_wr,
  output logic [7:0]    smp_dout,
  output logic          smp_wait_n,
  output logic [AW-1:0] pcm_addr,
  output logic          pcm_cs,
  input  logic [7:0]    pcm_data,
  input  logic          pcm_ok,
  output logic [7:0]    dac
);

  localparam logic [AW-1:0] ONE = AW'(1);

  pcm_st_t st, st_nx;
  logic    ptr_chg;
  logic    take;
  logic    unused_hi;

  assign ptr_chg   = smp_lo_wr | smp_hi_wr | dac_wr;
  assign unused_hi = ^snd_dout[7:AW-13];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nx;
    end
  end

  // A pointer change in the same clk as pcm_ok wins: the byte
  // belongs to the old address and is dropped.
  always_comb begin
    st_nx      = st;
    take       = 1'b0;
    pcm_cs     = 1'b0;
    smp_wait_n = 1'b1;
    unique case (st)
      ST_IDLE: begin
        if (ptr_chg) st_nx = ST_FETCH;
      end
      ST_FETCH: begin
        pcm_cs     = 1'b1;
        smp_wait_n = ~smp_rd;
        if (ptr_chg) begin
          st_nx = ST_FETCH;
        end else if (pcm_ok) begin
          take  = 1'b1;
          st_nx = ST_READY;
        end
      end
      ST_READY: begin
        if (ptr_chg) st_nx = ST_FETCH;
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm_addr <= '0;
    end else if (smp_lo_wr) begin
      pcm_addr <= {pcm_addr[AW-1:13], snd_dout, 5'd0};
    end else if (smp_hi_wr) begin
      pcm_addr <= {snd_dout[AW-14:0], pcm_addr[12:0]};
    end else if (dac_wr) begin
      pcm_addr <= pcm_addr + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_dout <= 8'h00;
    end else if (take) begin
      smp_dout <= pcm_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac <= 8'h80;
    end else if (dac_wr) begin
      dac <= snd_dout;
    end
  end

endmodule

// File: rtl/jtvigil_snd_if.sv
// Sound-CPU end of the main->sound latch: byte capture, IM0 RST vector, PCM pointer.
// Ports: clk, rst; latch_wr/main_dout (main CPU); snd_dout, latch_rd, irq_ack, ym_irq_n,
//   int_n, int_vec, latch_dout (sound CPU); smp_*/dac_wr, pcm_* ROM port, dac.
module jtvigil_snd_if
  import jtvigil_pkg::*;
#(
  parameter int SMP_AW = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              latch_wr,
  input  logic [7:0]        main_dout,
  input  logic [7:0]        snd_dout,
  input  logic              latch_rd,
  input  logic              irq_ack,
  input  logic              ym_irq_n,
  output logic              int_n,
  output logic [7:0]        int_vec,
  output logic [7:0]        latch_dout,
  input  logic              smp_lo_wr,
  input  logic              smp_hi_wr,
  input  logic              smp_rd,
  input  logic              dac_wr,
  output logic [7:0]        smp_dout,
  output logic              smp_wait_n,
  output logic [SMP_AW-1:0] pcm_addr,
  output logic              pcm_cs,
  input  logic [7:0]        pcm_data,
  input  logic              pcm_ok,
  output logic [7:0]        dac
);

  logic wr_l;
  logic wr_edge;
  logic latch_pend;
  logic ym_pend;
  logic unused_rd;

  // Reading the latch leaves the request pending; only irq_ack clears it.
  assign unused_rd = latch_rd;
  assign wr_edge   = latch_wr & ~wr_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_l       <= 1'b0;
      latch_dout <= 8'h00;
      latch_pend <= 1'b0;
      ym_pend    <= 1'b0;
    end else begin
      wr_l    <= latch_wr;
      ym_pend <= ~ym_irq_n;
      if (wr_edge) begin
        latch_dout <= main_dout;
        latch_pend <= 1'b1;
      end else if (irq_ack) begin
        latch_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    int_vec = VEC_NONE;
    if (latch_pend) int_vec[VEC_LATCH_BIT] = 1'b0;
    if (ym_pend)    int_vec[VEC_YM_BIT]    = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_n <= 1'b1;
    end else begin
      int_n <= int_vec == VEC_NONE;
    end
  end

  jtvigil_pcm_ptr #(
    .AW(SMP_AW)
  ) u_pcm (
    .clk        (clk),
    .rst        (rst),
    .snd_dout   (snd_dout),
    .smp_lo_wr  (smp_lo_wr),
    .smp_hi_wr  (smp_hi_wr),
    .smp_rd     (smp_rd),
    .dac_wr     (dac_wr),
    .smp_dout   (smp_dout),
    .smp_wait_n (smp_wait_n),
    .pcm_addr   (pcm_addr),
    .pcm_cs     (pcm_cs),
    .pcm_data   (pcm_data),
    .pcm_ok     (pcm_ok),
    .dac        (dac)
  );

endmodule
